lfsr_rand: RTL and testbench
============================

# lfsr_rand

Parametrised Galois LFSR pseudo-random source with seed load, lock-up protection and a request/valid/ready port that returns a uniformly distributed value in [0, limit) by rejection sampling. It serves the game logic (random spawn coordinates, tag-timer jitter) and any block that needs bounded random numbers. It also exposes the raw LFSR state for free-running use.

## Interface

Parameters:
- WIDTH, 16, LFSR state width; must be ≥ 3.
- TAPS, 16'hB400, Galois feedback mask, WIDTH bits; must be non-zero.
- SEED, 16'hACE1, reset and fallback seed, WIDTH bits; must be non-zero.
- OUT_W, 10, bounded output width; must satisfy 1 ≤ OUT_W ≤ WIDTH.
- MAX_TRIES, 8, rejection attempts before fallback; must be ≥ 1.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, advances the LFSR one step per cycle while FSM is IDLE or HOLD.
- seed_load, in, 1, loads `seed` into the LFSR.
- seed, in, WIDTH, seed value.
- state, out, WIDTH, current LFSR register.
- req, in, 1, request a bounded value; sampled only in IDLE.
- limit, in, OUT_W, exclusive upper bound; captured with `req`.
- busy, out, 1, high in DRAW and HOLD.
- valid, out, 1, high in HOLD.
- ready, in, 1, consumer accepts `value` when high with `valid`.
- value, out, OUT_W, result; stable while `valid` is high.
- biased, out, 1, high with `valid` when the fallback produced `value`.

## Operation

- Step: if state[0] is 1, next = (state >> 1) ^ TAPS; otherwise next = state >> 1.
- Advance priority:
  - `seed_load` beats any step.
  - A load of 0 stores SEED, so the all-zero lock-up state is unreachable.
- The LFSR advances every cycle in DRAW regardless of `en`; in IDLE and HOLD it advances only when `en` is high.
- FSM states: IDLE, DRAW, HOLD.
- IDLE:
  - On `req`, capture `limit` into limit_q, clear the try counter, then go to DRAW.
  - `req` in DRAW or HOLD is ignored.
- DRAW: each cycle, cand = state[OUT_W-1:0].
  - If limit_q == 0, value = 0, biased = 0, go to HOLD.
  - Else if cand < limit_q, value = cand, biased = 0, go to HOLD.
  - Else increment tries. When tries reaches MAX_TRIES, value = limit_q − 1, biased = 1, go to HOLD. Otherwise stay in DRAW.
- HOLD: when `valid` and `ready` are both high, go to IDLE at that edge.
- `seed_load` during DRAW is honoured. Later candidates come from the loaded sequence, and the try count is not reset.
- Comparison is unsigned, OUT_W bits wide.

## Timing

- Reset values:
  - state = SEED
  - FSM in IDLE
  - value = 0, valid = 0, busy = 0, biased = 0
  - limit_q = 0, tries = 0
- Reset asserted mid-DRAW or mid-HOLD aborts immediately. No `valid` is produced for the aborted request.
- Minimum latency: `req` high at edge N; DRAW at N+1, testing the state present in that cycle; `valid` high from edge N+2.
- Maximum latency: MAX_TRIES + 1 cycles from the `req` edge to `valid`.
- A new `req` is accepted no earlier than the cycle after the `ready` handshake, which gives one IDLE cycle between requests.
- `state` is a registered output with no combinational path from inputs.
- `value`, `valid` and `biased` are registered and hold while `ready` is low.

## Configuration

- LFSR_RAND_STATS_EN defined:
  - Adds output `reject_count` (16 bits), a saturating count of rejected candidates.
  - Adds output `fallback_count` (16 bits), a saturating count of biased results.
  - Both reset to 0 and saturate at 16'hFFFF.
- LFSR_RAND_STATS_EN undefined: neither port nor its counters exist. All other behaviour is identical.

## Test plan

- Reset, then `en` high for 3 cycles (defaults) -> `state` sequence 16'hACE1, 16'hE270, 16'h7138, 16'h389C.
- `seed_load` with seed = 0 -> `state` = 16'hACE1 the next cycle. Simultaneous `seed_load` and `en` -> the load wins.
- `req` with limit = 10'd1023 from reset state -> `valid` at N+2, value = 10'h0E1 (cand 0x0E1 < 1023), biased = 0. Hold `ready` low for 5 cycles -> `value` stable; `ready` high -> IDLE at the next edge.
- `req` with limit = 1 from reset state (cands 0x0E1, 0x270, 0x138, 0x09C, … all rejected) with MAX_TRIES = 4 -> `valid` at N+5, value = 0, biased = 1. With stats enabled, reject_count = 4 and fallback_count = 1.
- `req` with limit = 0 -> value = 0, biased = 0 at N+2. `req` pulsed during HOLD -> ignored, no second result.
- Assert rst_n low during DRAW -> `busy` = 0 and `valid` = 0 immediately; after release, `state` = SEED.

Source files
------------

// File: rtl/lfsr_rand.sv
// Galois LFSR random source with seed load and bounded draws by rejection sampling.
// Define LFSR_RAND_STATS_EN to add saturating reject/fallback counters.
module lfsr_rand #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               OUT_W     = 10,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [OUT_W-1:0] value,
  output logic             biased
`ifdef LFSR_RAND_STATS_EN
  ,
  output logic [15:0]      reject_count,
  output logic [15:0]      fallback_count
`endif
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} fsm_t;

  fsm_t             fsm;
  logic [OUT_W-1:0] limit_q;
  logic [TRY_W-1:0] tries;
  logic [TRY_W-1:0] tries_inc;
  logic [OUT_W-1:0] cand;
  logic             advance;
  logic             last_try;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  assign cand      = state[OUT_W-1:0];
  assign tries_inc = tries + TRY_W'(1);
  assign last_try  = (tries_inc == TRY_W'(MAX_TRIES));
  // Drawing needs a fresh candidate every cycle, so DRAW overrides en.
  assign advance   = (fsm == DRAW) || en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (seed_load) begin
      state <= (seed == '0) ? SEED : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      limit_q <= '0;
      tries   <= '0;
      value   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      biased  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            limit_q <= limit;
            tries   <= '0;
            busy    <= 1'b1;
            fsm     <= DRAW;
          end
        end
        DRAW: begin
          if (limit_q == '0) begin
            value  <= '0;
            biased <= 1'b0;
            valid  <= 1'b1;
            fsm    <= HOLD;
          end else if (cand < limit_q) begin
            value  <= cand;
            biased <= 1'b0;
            valid  <= 1'b1;
            fsm    <= HOLD;
          end else begin
            tries <= tries_inc;
            if (last_try) begin
              value  <= limit_q - OUT_W'(1);
              biased <= 1'b1;
              valid  <= 1'b1;
              fsm    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ready) begin
            valid  <= 1'b0;
            busy   <= 1'b0;
            biased <= 1'b0;
            fsm    <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_RAND_STATS_EN
  logic rej_ev;
  logic fb_ev;

  assign rej_ev = (fsm == DRAW) && (limit_q != '0) && !(cand < limit_q);
  assign fb_ev  = rej_ev && last_try;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_count   <= '0;
      fallback_count <= '0;
    end else begin
      if (rej_ev && (reject_count != 16'hFFFF)) reject_count <= reject_count + 16'd1;
      if (fb_ev && (fallback_count != 16'hFFFF)) fallback_count <= fallback_count + 16'd1;
    end
  end
`else
  // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_lfsr_rand.sv
// Directed bench for lfsr_rand: LFSR sequence, seed load, bounded draws, fallback, reset abort.
module tb_lfsr_rand;

  localparam int WIDTH     = 16;
  localparam int OUT_W     = 10;
  localparam int MAX_TRIES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] state;
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [OUT_W-1:0] value;
  logic             biased;
`ifdef LFSR_RAND_STATS_EN
  logic [15:0]      reject_count;
  logic [15:0]      fallback_count;
`endif

  lfsr_rand #(.MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
    .state(state), .req(req), .limit(limit), .busy(busy), .valid(valid),
    .ready(ready), .value(value), .biased(biased)
`ifdef LFSR_RAND_STATS_EN
    , .reject_count(reject_count), .fallback_count(fallback_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [OUT_W:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [OUT_W:0] e;
    if (sb.size() == 0) e = '1;
    else e = sb.pop_front();
    check({tag, "_value"}, 32'(value), 32'(e[OUT_W-1:0]));
    check({tag, "_biased"}, 32'(biased), 32'(e[OUT_W]));
  endtask

  initial begin
    logic [OUT_W-1:0] held;
    int lat;
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = 16'hE270; exp_seq[1] = 16'h7138; exp_seq[2] = 16'h389C;

    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed = '0;
    req = 1'b0; limit = '0; ready = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state), 32'h0000ACE1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_biased", 32'(biased), 32'd0);
`ifdef LFSR_RAND_STATS_EN
    check("rst_rej", 32'(reject_count), 32'd0);
    check("rst_fb", 32'(fallback_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("seq0", 32'(state), 32'h0000ACE1);

    // Free-running steps
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("seq%0d", i + 1), 32'(state), 32'(exp_seq[i]));
    end

    // Load beats step; zero seed falls back to SEED
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    check("load_zero", 32'(state), 32'h0000ACE1);
    seed = 16'h1234;
    tick();
    check("load_1234", 32'(state), 32'h00001234);
    seed = 16'h0000;
    tick();
    seed_load = 1'b0; en = 1'b0;
    tick();
    check("idle_hold", 32'(state), 32'h0000ACE1);

    // Accepted on first candidate
    req = 1'b1; limit = 10'd1023;
    sb.push_back({1'b0, 10'h0E1});
    tick();
    req = 1'b0;
    check("draw_busy", 32'(busy), 32'd1);
    check("draw_novalid", 32'(valid), 32'd0);
    wait_valid(lat);
    check("lat_min", 32'(lat), 32'd1);
    sb_compare("acc");
    held = value;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_value", 32'(value), 32'(held));
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hs_valid", 32'(valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);

    // All candidates rejected -> fallback
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    req = 1'b1; limit = 10'd1;
    sb.push_back({1'b1, 10'd0});
    tick();
    req = 1'b0;
    wait_valid(lat);
    check("lat_max", 32'(lat), 32'(MAX_TRIES));
    sb_compare("fb");
`ifdef LFSR_RAND_STATS_EN
    check("rej_count", 32'(reject_count), 32'd4);
    check("fb_count", 32'(fallback_count), 32'd1);
`endif
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("fb_hs_valid", 32'(valid), 32'd0);

    // limit 0, and req during HOLD ignored
    req = 1'b1; limit = 10'd0;
    sb.push_back({1'b0, 10'd0});
    tick();
    req = 1'b0;
    wait_valid(lat);
    check("lat_zero", 32'(lat), 32'd1);
    sb_compare("zero");
    req = 1'b1; limit = 10'd5;
    tick();
    req = 1'b0;
    check("hold_req_valid", 32'(valid), 32'd1);
    check("hold_req_value", 32'(value), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_second_valid", 32'(valid), 32'd0);
      check("no_second_busy", 32'(busy), 32'd0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset aborts an in-flight draw
    req = 1'b1; limit = 10'd1;
    tick();
    req = 1'b0;
    check("abort_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_state", 32'(state), 32'h0000ACE1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", 32'(valid), 32'd0);
    end
    check("post_rst_state", 32'(state), 32'h0000ACE1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
